pipe_stage_skid: RTL



---
 rtl/pipe_stage_skid_if.sv | 26 ++
 rtl/pipe_stage_skid.sv | 99 +++++++++
 2 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between an upstream producer, the elastic stage and
// a downstream consumer. The stage uses the slave view; the driver of
// the stage (testbench or surrounding pipeline) uses the master view.
interface pipe_stage_skid_if #(
   parameter int DW = 64
);
   logic          hold_i;
   logic          flush_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] in_data_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [DW-1:0] out_data_o;
   logic [1:0]    count_o;

   modport slave (
      input  hold_i, flush_i, in_valid_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, count_o
   );

   modport master (
      output hold_i, flush_i, in_valid_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, count_o
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: one output (main) register plus one skid
// register behind a valid/ready handshake. The upstream ready depends only
// on registered state and hold, so the stage breaks the ready path while
// still sustaining one transfer per cycle. Empty or flushed entries carry
// the BUBBLE value so downstream always sees a harmless payload.
module pipe_stage_skid #(
   parameter int            DW     = 64,
   parameter logic [DW-1:0] BUBBLE = {DW{1'b0}}
) (
   input logic              clk,
   input logic              rst,
   pipe_stage_skid_if.slave bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t        state_p0, state_nxt;
   logic [DW-1:0] main_data_p0, main_data_nxt;
   logic [DW-1:0] skid_data_p0, skid_data_nxt;
   logic          push, pop;
   logic          in_ready, out_valid;

   // Handshake qualifiers: registered state gated only by hold.
   always_comb begin
      in_ready  = (state_p0 != FULL) && !bus.hold_i;
      out_valid = (state_p0 != EMPTY) && !bus.hold_i;
      push      = bus.in_valid_i && in_ready;
      pop       = out_valid && bus.out_ready_i;
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid;
   assign bus.out_data_o  = main_data_p0;
   assign bus.count_o     = 2'(state_p0);

   // Next-state and next-payload; flush beats handshake, hold blocks it.
   always_comb begin
      state_nxt     = state_p0;
      main_data_nxt = main_data_p0;
      skid_data_nxt = skid_data_p0;
      if (bus.flush_i) begin
         state_nxt     = EMPTY;
         main_data_nxt = BUBBLE;
         skid_data_nxt = BUBBLE;
      end else begin
         case (state_p0)
            EMPTY: begin
               if (push) begin
                  state_nxt     = ONE;
                  main_data_nxt = bus.in_data_i;
               end
            end
            ONE: begin
               if (push && pop) begin
                  main_data_nxt = bus.in_data_i;
               end else if (push) begin
                  state_nxt     = FULL;
                  skid_data_nxt = bus.in_data_i;
               end else if (pop) begin
                  state_nxt     = EMPTY;
                  main_data_nxt = BUBBLE;
               end
            end
            FULL: begin
               // The skid entry is older than anything upstream, so it
               // moves forward and no new input is taken this cycle.
               if (pop) begin
                  state_nxt     = ONE;
                  main_data_nxt = skid_data_p0;
                  skid_data_nxt = BUBBLE;
               end
            end
            default: begin
               state_nxt     = EMPTY;
               main_data_nxt = BUBBLE;
               skid_data_nxt = BUBBLE;
            end
         endcase
      end
   end

   // State and payload registers; reset returns both entries to BUBBLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0     <= EMPTY;
         main_data_p0 <= BUBBLE;
         skid_data_p0 <= BUBBLE;
      end else begin
         state_p0     <= state_nxt;
         main_data_p0 <= main_data_nxt;
         skid_data_p0 <= skid_data_nxt;
      end
   end

endmodule
